// File: rtl/prs_pkg.sv
// Shared encodings, state type and outcome rule for the rock-paper-scissors sequencer.
package prs_pkg;

   localparam logic [1:0] CH_ROCK     = 2'd0;
   localparam logic [1:0] CH_PAPER    = 2'd1;
   localparam logic [1:0] CH_SCISSORS = 2'd2;

   localparam logic [3:0] TXT_BLANK    = 4'd0;
   localparam logic [3:0] TXT_ROCK     = 4'd1;
   localparam logic [3:0] TXT_PAPER    = 4'd2;
   localparam logic [3:0] TXT_SCISSORS = 4'd3;
   localparam logic [3:0] TXT_WIN      = 4'd4;
   localparam logic [3:0] TXT_LOSE     = 4'd5;
   localparam logic [3:0] TXT_TIE      = 4'd6;
   localparam logic [3:0] TXT_PLAY     = 4'd7;
   localparam logic [3:0] TXT_OVER     = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHOOSE    = 3'd1,
      ST_REVEAL    = 3'd2,
      ST_RESULT    = 3'd3,
      ST_GAME_OVER = 3'd4
   } prs_state_t;

   function automatic logic [1:0] prs_next_choice(input logic [1:0] ch);
      return (ch == CH_SCISSORS) ? CH_ROCK : ch + 2'd1;
   endfunction

   // Player wins exactly when it is one step ahead of the CPU in the mod-3 cycle.
   function automatic logic [3:0] prs_outcome(input logic [1:0] player, input logic [1:0] cpu);
      logic [3:0] code;
      if (player == cpu) begin
         code = TXT_TIE;
      end else if (player == prs_next_choice(cpu)) begin
         code = TXT_WIN;
      end else begin
         code = TXT_LOSE;
      end
      return code;
   endfunction

endpackage

// File: rtl/prs_event_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module prs_event_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic ev
);

   logic sync1_q, sync2_q, prev_q, ev_q;
   logic ev_d;

   always_comb begin
      ev_d = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         ev_q    <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         ev_q    <= ev_d;
      end
   end

   assign ev = ev_q;

endmodule

// File: rtl/prs_controller.sv
// Round sequencer and scorekeeper for rock-paper-scissors; all outputs are registered.
module prs_controller
   import prs_pkg::*;
#(
   parameter int unsigned REVEAL_CYCLES = 50_000_000,
   parameter int unsigned RESULT_CYCLES = 50_000_000,
   parameter int unsigned WIN_TARGET    = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       click,
   input  logic       selection,
   output logic [3:0] text,
   output logic       enable,
   output logic [1:0] player_choice,
   output logic [1:0] cpu_choice,
   output logic [3:0] wins,
   output logic [3:0] losses,
   output logic       round_done,
   output logic       game_over
);

   localparam logic [31:0] REVEAL_LOAD = 32'(REVEAL_CYCLES - 1);
   localparam logic [31:0] RESULT_LOAD = 32'(RESULT_CYCLES - 1);
   localparam logic [3:0]  TARGET      = 4'(WIN_TARGET);

   logic clk_ev, sel_ev;

   prs_event_sync u_click_sync (
      .clk   (CLK),
      .rst_n (RESET),
      .din   (click),
      .ev    (clk_ev)
   );

   prs_event_sync u_sel_sync (
      .clk   (CLK),
      .rst_n (RESET),
      .din   (selection),
      .ev    (sel_ev)
   );

   prs_state_t  state_q, state_d;
   logic [3:0]  text_q, text_d;
   logic        enable_q, enable_d;
   logic [1:0]  player_q, player_d;
   logic [1:0]  cpu_q, cpu_d;
   logic [1:0]  cpu_ctr_q, cpu_ctr_d;
   logic [3:0]  wins_q, wins_d;
   logic [3:0]  losses_q, losses_d;
   logic [3:0]  outcome_q, outcome_d;
   logic [31:0] timer_q, timer_d;
   logic        round_done_q, round_done_d;
   logic        game_over_q, game_over_d;

   always_comb begin
      state_d      = state_q;
      player_d     = player_q;
      cpu_d        = cpu_q;
      wins_d       = wins_q;
      losses_d     = losses_q;
      outcome_d    = outcome_q;
      timer_d      = timer_q;
      round_done_d = 1'b0;
      cpu_ctr_d    = prs_next_choice(cpu_ctr_q);

      case (state_q)
         ST_IDLE: begin
            if (clk_ev) begin
               state_d  = ST_CHOOSE;
               player_d = CH_ROCK;
            end
         end
         ST_CHOOSE: begin
            // A click in the same cycle as a scroll takes priority; the scroll is dropped.
            if (clk_ev) begin
               cpu_d   = cpu_ctr_q;
               timer_d = REVEAL_LOAD;
               state_d = ST_REVEAL;
            end else if (sel_ev) begin
               player_d = prs_next_choice(player_q);
            end
         end
         ST_REVEAL: begin
            if (timer_q == 32'd0) begin
               state_d      = ST_RESULT;
               timer_d      = RESULT_LOAD;
               outcome_d    = prs_outcome(player_q, cpu_q);
               round_done_d = 1'b1;
               if (outcome_d == TXT_WIN) begin
                  wins_d = wins_q + 4'd1;
               end else if (outcome_d == TXT_LOSE) begin
                  losses_d = losses_q + 4'd1;
               end
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_RESULT: begin
            if (timer_q == 32'd0) begin
               if (wins_q == TARGET || losses_q == TARGET) begin
                  state_d = ST_GAME_OVER;
               end else begin
                  state_d = ST_CHOOSE;
               end
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_GAME_OVER: begin
            if (clk_ev) begin
               wins_d   = 4'd0;
               losses_d = 4'd0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Display follows the upcoming state so text changes on the same edge as the state.
      text_d = TXT_BLANK;
      case (state_d)
         ST_IDLE:      text_d = TXT_PLAY;
         ST_CHOOSE:    text_d = {2'b00, player_d} + 4'd1;
         ST_REVEAL:    text_d = {2'b00, cpu_d} + 4'd1;
         ST_RESULT:    text_d = outcome_d;
         ST_GAME_OVER: text_d = TXT_OVER;
         default:      text_d = TXT_BLANK;
      endcase
      enable_d    = 1'b1;
      game_over_d = (state_d == ST_GAME_OVER);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= ST_IDLE;
         text_q       <= TXT_BLANK;
         enable_q     <= 1'b0;
         player_q     <= CH_ROCK;
         cpu_q        <= CH_ROCK;
         cpu_ctr_q    <= 2'd0;
         wins_q       <= 4'd0;
         losses_q     <= 4'd0;
         outcome_q    <= TXT_BLANK;
         timer_q      <= 32'd0;
         round_done_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         text_q       <= text_d;
         enable_q     <= enable_d;
         player_q     <= player_d;
         cpu_q        <= cpu_d;
         cpu_ctr_q    <= cpu_ctr_d;
         wins_q       <= wins_d;
         losses_q     <= losses_d;
         outcome_q    <= outcome_d;
         timer_q      <= timer_d;
         round_done_q <= round_done_d;
         game_over_q  <= game_over_d;
      end
   end

   assign text          = text_q;
   assign enable        = enable_q;
   assign player_choice = player_q;
   assign cpu_choice    = cpu_q;
   assign wins          = wins_q;
   assign losses        = losses_q;
   assign round_done    = round_done_q;
   assign game_over     = game_over_q;

endmodule

// File: tb/tb_prs_controller.sv
// Directed bench for prs_controller with short reveal/result windows and a target of 2.
module tb_prs_controller;

   logic       clk;
   logic       rst_n;
   logic       click;
   logic       selection;
   logic [3:0] text;
   logic       enable;
   logic [1:0] player_choice;
   logic [1:0] cpu_choice;
   logic [3:0] wins;
   logic [3:0] losses;
   logic       round_done;
   logic       game_over;

   int total = 0;
   int bad   = 0;
   int edges = 0;

   prs_controller #(
      .REVEAL_CYCLES (4),
      .RESULT_CYCLES (4),
      .WIN_TARGET    (2)
   ) dut (
      .CLK           (clk),
      .RESET         (rst_n),
      .click         (click),
      .selection     (selection),
      .text          (text),
      .enable        (enable),
      .player_choice (player_choice),
      .cpu_choice    (cpu_choice),
      .wins          (wins),
      .losses        (losses),
      .round_done    (round_done),
      .game_over     (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; the CPU counter's phase is this count mod 3.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Raise the inputs for one cycle; returns on the first cycle after the FSM reacted.
   task automatic press(input bit c, input bit s);
      click = c;
      selection = s;
      tick();
      click = 1'b0;
      selection = 1'b0;
      repeat (3) tick();
   endtask

   // A click raised after N edges is accepted with cpu = N mod 3.
   task automatic wait_phase(input int p);
      for (int i = 0; i < 3 && (edges % 3) != p; i++) tick();
   endtask

   task automatic run_round(input int cpu_exp, input int res_exp, input int w_exp,
                            input int l_exp, input int next_text);
      chk("cpu_choice", cpu_choice, cpu_exp);
      for (int i = 0; i < 4; i++) begin
         chk("reveal_text", text, cpu_exp + 1);
         tick();
      end
      chk("result_text", text, res_exp);
      chk("round_done_hi", round_done, 1);
      chk("wins", wins, w_exp);
      chk("losses", losses, l_exp);
      tick();
      for (int i = 1; i < 4; i++) begin
         chk("result_hold", text, res_exp);
         chk("round_done_lo", round_done, 0);
         tick();
      end
      chk("after_result", text, next_text);
   endtask

   initial begin
      rst_n = 1'b0;
      click = 1'b0;
      selection = 1'b0;
      repeat (3) tick();

      // 1: reset state and first cycle after release
      chk("rst_text", text, 0);
      chk("rst_enable", enable, 0);
      chk("rst_wins", wins, 0);
      chk("rst_game_over", game_over, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_text", text, 7);
      chk("idle_enable", enable, 1);

      // 2: enter CHOOSE and scroll through all choices with wrap
      press(1, 0);
      chk("choose_rock", text, 1);
      press(0, 1);
      chk("choose_paper", text, 2);
      press(0, 1);
      chk("choose_scissors", text, 3);
      press(0, 1);
      chk("choose_wrap", text, 1);
      chk("player_wrap", player_choice, 0);

      // 3: PAPER vs ROCK wins, then PAPER vs PAPER ties
      press(0, 1);
      chk("choose_paper2", text, 2);
      wait_phase(0);
      press(1, 0);
      chk("locked_player", player_choice, 1);
      run_round(0, 4, 1, 0, 2);
      wait_phase(1);
      press(1, 0);
      run_round(1, 6, 1, 0, 2);

      // 4: click and scroll together; click wins, PAPER vs SCISSORS loses
      wait_phase(2);
      press(1, 1);
      chk("simul_player", player_choice, 1);
      run_round(2, 5, 1, 1, 2);

      // 5: second loss ends the game, click restarts
      wait_phase(2);
      press(1, 0);
      run_round(2, 5, 1, 2, 8);
      chk("game_over_hi", game_over, 1);
      press(1, 0);
      chk("restart_text", text, 7);
      chk("restart_wins", wins, 0);
      chk("restart_losses", losses, 0);
      chk("game_over_lo", game_over, 0);

      // 6: ROCK vs SCISSORS with a click during REVEAL, then reset in RESULT
      press(1, 0);
      chk("choose_rock2", text, 1);
      wait_phase(2);
      press(1, 0);
      chk("reveal_c1", text, 3);
      click = 1'b1;
      tick();
      click = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("reveal_ignore", text, 3);
         tick();
      end
      chk("result_win", text, 4);
      chk("result_wins", wins, 1);
      tick();
      chk("result_not_choose", text, 4);
      rst_n = 1'b0;
      #1;
      chk("arst_text", text, 0);
      chk("arst_enable", enable, 0);
      chk("arst_wins", wins, 0);
      chk("arst_cpu", cpu_choice, 0);
      chk("arst_round_done", round_done, 0);
      chk("arst_game_over", game_over, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rerun_text", text, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
